// File: rtl/ramio_unit.sv
// ramio_unit: load/store aligner between the rv32i core and the memory port, with a small MMIO window (LEDs, UART TX).
// Build option RAMIO_CYCLE_COUNTER_EN exposes a free-running cycle counter at IoBase+8.
module ramio_unit #(
   parameter logic [31:0] IoBase   = 32'hFFFF_FFF0,
   parameter int          LedWidth = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_enable,
   input  logic [2:0]          i_read_type,
   input  logic [1:0]          i_write_type,
   input  logic [31:0]         i_address,
   input  logic [31:0]         i_data_in,
   output logic [31:0]         o_data_out,
   output logic                o_data_out_ready,
   output logic                o_busy,
   output logic                o_err,
   output logic                o_mem_req,
   output logic [29:0]         o_mem_addr,
   output logic [3:0]          o_mem_we,
   output logic [31:0]         o_mem_wdata,
   input  logic [31:0]         i_mem_rdata,
   input  logic                i_mem_ack,
   output logic [LedWidth-1:0] o_led,
   output logic [7:0]          o_uart_tx_data,
   output logic                o_uart_tx_go,
   input  logic                i_uart_tx_busy
);
   typedef enum logic [1:0] {IDLE, MEM_WAIT, UART_WAIT, COMPLETE} state_t;
   state_t r_state, w_next;
   logic [31:0] r_addr, r_wdata, r_data_out, w_io_rdata, w_shift, w_load, w_cnt;
   logic [1:0] r_size, w_size, w_io_sel;
   logic [3:0] w_be;
   logic [LedWidth-1:0] r_led;
   logic [7:0] r_tx_data;
   logic r_wr, r_sgn, r_err, r_tx_go, w_cap, w_wr, w_misal, w_io;
   assign w_cap = i_enable && (i_read_type != 3'd0 || i_write_type != 2'd0);
   assign w_wr = i_write_type != 2'd0;
   assign w_size = w_wr ? i_write_type : i_read_type[1:0];
   assign w_misal = (w_size == 2'b10 && i_address[1:0] == 2'd3) || (w_size == 2'b11 && i_address[1:0] != 2'd0);
   assign w_io = i_address >= IoBase;
   // IoBase is word aligned, so the register select needs only address bits [3:2]
   assign w_io_sel = i_address[3:2] - IoBase[3:2];
   assign w_io_rdata = (w_io_sel == 2'd0) ? 32'(r_led) :
                       (w_io_sel == 2'd1) ? {31'd0, i_uart_tx_busy} :
                       (w_io_sel == 2'd2) ? w_cnt : 32'd0;
`ifdef RAMIO_CYCLE_COUNTER_EN
   logic [31:0] r_cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_cnt <= '0;
      else r_cnt <= r_cnt + 32'd1;
   assign w_cnt = r_cnt;
`else
   assign w_cnt = '0;
`endif
   assign w_shift = i_mem_rdata >> {r_addr[1:0], 3'b000};
   assign w_load = (r_size == 2'b01) ? {{24{r_sgn & w_shift[7]}}, w_shift[7:0]} :
                   (r_size == 2'b10) ? {{16{r_sgn & w_shift[15]}}, w_shift[15:0]} : w_shift;
   assign w_be = (r_size == 2'b01) ? (4'b0001 << r_addr[1:0]) :
                 (r_size == 2'b10) ? (4'b0011 << r_addr[1:0]) : 4'b1111;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (w_cap) w_next = w_misal ? COMPLETE : !w_io ? MEM_WAIT :
                                        (w_wr && w_io_sel == 2'd1) ? UART_WAIT : COMPLETE;
         MEM_WAIT:  if (i_mem_ack) w_next = COMPLETE;
         UART_WAIT: if (!i_uart_tx_busy) w_next = COMPLETE;
         default:   w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_size     <= '0;
         r_wr       <= 1'b0;
         r_sgn      <= 1'b0;
         r_err      <= 1'b0;
         r_data_out <= '0;
         r_led      <= '1;
         r_tx_data  <= '0;
         r_tx_go    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_tx_go <= 1'b0;
         if (r_state == IDLE && w_cap) begin
            r_addr  <= i_address;
            r_wdata <= i_data_in;
            r_size  <= w_size;
            r_wr    <= w_wr;
            r_sgn   <= i_read_type[2];
            if (w_misal) begin
               r_err <= 1'b1;
               if (!w_wr) r_data_out <= '0;
            end else if (w_io) begin
               if (!w_wr) r_data_out <= w_io_rdata;
               else if (w_io_sel == 2'd0) r_led <= i_data_in[LedWidth-1:0];
            end
         end
         if (r_state == MEM_WAIT && i_mem_ack && !r_wr) r_data_out <= w_load;
         if (r_state == UART_WAIT && !i_uart_tx_busy) begin
            r_tx_go   <= 1'b1;
            r_tx_data <= r_wdata[7:0];
         end
      end
   assign o_mem_req = r_state == MEM_WAIT;
   assign o_mem_addr = o_mem_req ? r_addr[31:2] : '0;
   assign o_mem_we = (o_mem_req && r_wr) ? w_be : 4'b0000;
   assign o_mem_wdata = !(o_mem_req && r_wr) ? 32'd0 :
                        (r_size == 2'b01) ? {4{r_wdata[7:0]}} :
                        (r_size == 2'b10) ? {2{r_wdata[15:0]}} : r_wdata;
   // Complete never captures, so a core retargeting the bus on ready cannot re-trigger the old request
   assign o_busy = (r_state != COMPLETE) && (r_state != IDLE || (i_enable && i_write_type != 2'd0));
   assign o_data_out_ready = (r_state == COMPLETE) && !r_wr;
   assign o_data_out = r_data_out;
   assign o_err = r_err;
   assign o_led = r_led;
   assign o_uart_tx_data = r_tx_data;
   assign o_uart_tx_go = r_tx_go;
endmodule

// File: doc/ramio_unit.md
Name: ramio_unit

Overview:
- Sits directly downstream of the rv32i core and upstream of the cache/memory port.
- Accepts the core's ramio request bus (enable, read/write type, byte address, data). Performs byte-lane alignment for sub-word stores and extraction plus sign/zero extension for sub-word loads.
- Decodes a small memory-mapped IO window (LEDs, UART TX).
- Presents the core with a one-cycle data_out_ready pulse and a busy flag.

Parameters:
- IoBase, 32'hFFFF_FFF0, base byte address of IO window (16 bytes); addresses >= IoBase are IO, all others are memory.
- LedWidth, 6, number of LED bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  request valid
- read_type  in  3  bit2 signed; [1:0] 01 byte, 10 half, 11 word; 000 no read
- write_type  in  2  01 byte, 10 half, 11 word; 00 no write
- address  in  32  byte address
- data_in  in  32  store data, right-justified
- data_out  out  32  load result, extended
- data_out_ready  out  1  one-cycle pulse, data_out valid
- busy  out  1  request in progress
- err  out  1  sticky misaligned-access flag
- mem_req  out  1  memory request
- mem_addr  out  30  word address (address[31:2])
- mem_we  out  4  byte write enables; 0000 means read
- mem_wdata  out  32  lane-aligned store data
- mem_rdata  in  32  read word
- mem_ack  in  1  one-cycle completion from memory
- led  out  LedWidth  LED register
- uart_tx_data  out  8  byte to transmit
- uart_tx_go  out  1  one-cycle start pulse
- uart_tx_busy  in  1  transmitter busy

Behaviour:
- Reset values:
  - All outputs 0, except led = all ones (LEDs off).
  - State Idle.
- States: Idle, MemWait, UartWait, Complete.
- Idle:
  - Request captured when enable=1 and (read_type!=0 or write_type!=0).
  - Address, types and data are latched on capture.
  - Write takes priority if both types are non-zero.
- Misalignment: half at offset 3, or word at offset !=0.
  - Sets err=1 (sticky until reset). No memory/IO access.
  - Reads return data_out=0 with ready pulse. Writes are discarded.
  - Goes to Complete.
- Memory access:
  - mem_req asserts the cycle after capture and holds until mem_ack. Then Complete.
  - mem_we for a byte write: 1<<offset. For a half write: 0011<<offset. For a word write: 1111.
  - mem_wdata replicates data_in into the selected lanes.
- Load extraction:
  - Byte = rdata[8*off+:8]; half = rdata[8*off+:16].
  - Sign-extend when read_type[2]=1, else zero-extend.
  - data_out registered; data_out_ready pulses in the cycle the state becomes Complete.
- IO window (offset = address - IoBase); all accesses complete without memory access.
  - +0 led: write loads data_in[LedWidth-1:0]; read returns led, zero-extended.
  - +4 UART TX: write goes to UartWait until uart_tx_busy=0, then drives uart_tx_data = data_in[7:0] and pulses uart_tx_go for 1 cycle, then Complete.
  - +4 read: returns {31'b0, uart_tx_busy}.
  - +8 and +12: reads return 0; writes are ignored.
- Complete:
  - Lasts exactly one cycle and never captures a request. This lets the core retarget the bus after ready/!busy without a stale re-capture.
  - Then Idle.
- busy (combinational) = (state != Complete) && (state != Idle || (enable && write_type != 0)). busy is therefore high in the same cycle a write is first presented.
- data_out_ready is never high two consecutive cycles.
- Latency:
  - Memory read: capture + mem latency + 1. Minimum 3 cycles from enable to ready with a 1-cycle ack.
  - IO read: ready 2 cycles after capture.
- enable dropping mid-operation is ignored; the operation finishes.
- Reset mid-operation: immediate return to Idle, mem_req=0, no pulse emitted.

Optional Feature:
- Macro RAMIO_CYCLE_COUNTER_EN.
- Defined:
  - 32-bit free-running counter, reset 0, increments every clk and wraps from FFFF_FFFF to 0.
  - Readable at IoBase+8, returning the value at capture time; writes ignored.
- Undefined: IoBase+8 reads 0 and no counter logic exists.

Test Plan:
- Store 0xAABBCCDD word to 0x100 with 1-cycle ack -> mem_we=1111, mem_wdata=AABBCCDD, busy high same cycle as enable, low in Complete, err=0.
- Load byte signed (101) from 0x103 with mem_rdata=0x80112233 -> data_out=FFFFFF80. Unsigned (001) -> 00000080. Single ready pulse.
- Store half 0x1234 to 0x102 -> mem_we=1100, mem_wdata[31:16]=1234. Store half to 0x103 -> err=1, no mem_req, busy released.
- Write 0x2A to IoBase+0 -> led=101010. Read IoBase+0 -> data_out=0000002A.
- Write 'A' to IoBase+4 with uart_tx_busy high 5 cycles -> uart_tx_go pulses once after busy falls with data 0x41, then Complete.
- Back-to-back: load then fetch retargeted in the ready cycle -> second access uses the new address, with no duplicate ready. Assert rst_n low during MemWait -> all outputs return to reset values.
